lsu_apb_master: RTL and testbench
=================================

Name: lsu_apb_master

Overview:
- APB requester that turns pipeline load/store requests from the LSU into APB transfers toward the data-memory and peripheral responders.
- Owns the protocol on its side of the bus:
  - SETUP/ACCESS sequencing and wait states on pready_i.
  - Byte-lane placement of store data, and pstrb generation.
  - Misalignment checking.
  - Lane extraction and sign/zero extension of load data.
- Sits between the MEM stage and the APB bus. It stalls the pipeline through req_ready_o until the response returns.

Parameters:
- PADDR_W, 6, width of the APB word address; paddr_o = req_addr_i[PADDR_W+1:2].
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without pready_i before abort. Used only with APB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  pipeline request valid
- req_ready_o  out  1  request accepted this cycle (high only in IDLE)
- req_write_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- req_funct_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid_o  out  1  one-cycle pulse: transfer complete
- rsp_rdata_o  out  32  extended load data (0 for stores and errors)
- rsp_err_o  out  1  valid with rsp_valid_o: misaligned, illegal funct, pslverr or timeout
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- paddr_o  out  PADDR_W  APB word address
- pwdata_o  out  32  lane-aligned write data
- pstrb_o  out  4  byte strobes
- pfunct_code_o  out  3  funct3 passed to the responder
- prdata_i  in  32  read data, full word
- pready_i  in  1  responder ready
- pslverr_i  in  1  responder error

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, except req_ready_o = 1. Reset asserted mid-transfer aborts the transfer with no response pulse.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready_o = 1.
  - If req_valid_i: latch write, addr, wdata and funct, then check the request.
  - Request is illegal if funct is 011, 110 or 111, or if misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0. Stores with funct 100/101 are also illegal.
  - Illegal request: go to RESP with err = 1. No bus activity.
  - Legal request: go to SETUP.
- SETUP: psel_o = 1, penable_o = 0, address/data/strobe stable. Always moves to ACCESS after one cycle.
- ACCESS: psel_o = 1, penable_o = 1, all bus outputs held stable.
  - pready_i = 1: capture prdata_i and pslverr_i, go to RESP.
  - pready_i = 0: stay in ACCESS (wait state).
- RESP: rsp_valid_o = 1 for exactly one cycle, psel_o = 0, then go to IDLE.
- Minimum latency: accepted at cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o at N+3 with zero wait states. Each wait state adds one cycle. An illegal request gives rsp_valid_o at N+1.
- Back-to-back requests: the next request is accepted in the IDLE cycle after RESP. Peak throughput is one transfer per 4 cycles.
- Strobes:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
  - Loads: pstrb_o = 0000.
- Write data placement: pwdata_o = req_wdata_i << (8*addr[1:0]). Loads drive pwdata_o = 0.
- Load data: select the byte or halfword of prdata_i given by addr[1:0], then extend.
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- pslverr_i set on the completing cycle: rsp_err_o = 1 and rsp_rdata_o = 0.
- rsp_rdata_o and rsp_err_o are registered and held until the next response.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments every ACCESS cycle with pready_i = 0. When it reaches TIMEOUT_CYCLES, drop psel_o/penable_o and go to RESP with rsp_err_o = 1 and rsp_rdata_o = 0.
- Undefined: no counter. ACCESS waits for pready_i indefinitely.

Decomposition:
- Package lsu_pkg:
  - funct3 enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - APB FSM state enum.
  - Strobe constants.
- Sub-module lsu_align: purely combinational. Provides strobe/wdata lane placement, the misalign/illegal check, and load extraction/extension. It is instantiated once, with the FSM and registers kept in lsu_apb_master.

Test Plan:
- SW of 0xDEADBEEF at 0x08, pready_i tied 1:
  - SETUP cycle shows paddr_o = 2, pstrb_o = 1111, pwdata_o = 0xDEADBEEF.
  - rsp_valid_o exactly 3 cycles after acceptance, rsp_err_o = 0.
- SB of 0x000000A5 at 0x0E: pstrb_o = 0100, pwdata_o = 0x00A50000, paddr_o = 3.
- Load from 0x0D with prdata_i = 0x1234_80FF:
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
  - LH from 0x0E → 0x00001234.
- LW with pready_i low for 3 cycles:
  - penable_o stays high for 4 cycles with the bus outputs stable.
  - rsp_valid_o arrives 6 cycles after acceptance.
- LH at 0x05, and separately funct 011:
  - psel_o never asserts.
  - rsp_valid_o pulses 1 cycle after acceptance with rsp_err_o = 1.
- pslverr_i = 1 on the completing cycle → rsp_err_o = 1, rsp_rdata_o = 0.
- With APB_TIMEOUT_EN and pready_i stuck at 0 → rsp_err_o = 1 after 16 ACCESS cycles.
- rst_ni pulsed during ACCESS → psel_o drops immediately, no rsp_valid_o pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU APB requester and its lane-alignment helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: strobe/write-data placement, legality check,
// and load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        write,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] lane_wdata,
    output logic        illegal,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        strb       = STRB_NONE;
        illegal    = 1'b0;
        load_data  = '0;
        shifted    = rdata >> {offset, 3'b000};
        lane_wdata = write ? (wdata << {offset, 3'b000}) : '0;
        case (funct)
            LSU_B: begin
                strb      = STRB_B << offset;
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            LSU_BU: begin
                load_data = {24'b0, shifted[7:0]};
                illegal   = write;
            end
            LSU_H: begin
                strb      = STRB_H << offset;
                load_data = {{16{shifted[15]}}, shifted[15:0]};
                illegal   = offset[0];
            end
            LSU_HU: begin
                load_data = {16'b0, shifted[15:0]};
                illegal   = write | offset[0];
            end
            LSU_W: begin
                strb      = STRB_W;
                load_data = rdata;
                illegal   = offset != 2'b00;
            end
            default: illegal = 1'b1;
        endcase
        if (!write) begin
            strb = STRB_NONE;
        end
    end

endmodule

// File: rtl/lsu_apb_master.sv
// APB requester for LSU loads/stores: SETUP/ACCESS sequencing, wait states, error response.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module lsu_apb_master
    import lsu_pkg::*;
#(
    parameter int unsigned PADDR_W        = 6,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [31:0]        req_addr_i,
    input  logic [31:0]        req_wdata_i,
    input  logic [2:0]         req_funct_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [PADDR_W-1:0] paddr_o,
    output logic [31:0]        pwdata_o,
    output logic [3:0]         pstrb_o,
    output logic [2:0]         pfunct_code_o,
    input  logic [31:0]        prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i
);

    apb_state_e state, state_next;

    logic               write_q;
    logic [PADDR_W+1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [2:0]         funct_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic        idle;
    logic        timeout;
    logic        sel_write;
    logic [1:0]  sel_offset;
    logic [2:0]  sel_funct;
    logic [3:0]  strb;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        illegal;
    logic        addr_unused;

    assign addr_unused = ^req_addr_i[31:PADDR_W+2];
    assign idle        = state == ST_IDLE;

    // One aligner serves both the acceptance check (live request) and the bus phase (latched request).
    assign sel_write  = idle ? req_write_i      : write_q;
    assign sel_offset = idle ? req_addr_i[1:0]  : addr_q[1:0];
    assign sel_funct  = idle ? req_funct_i      : funct_q;

    lsu_align u_align (
        .write      (sel_write),
        .offset     (sel_offset),
        .funct      (sel_funct),
        .wdata      (wdata_q),
        .rdata      (prdata_i),
        .strb       (strb),
        .lane_wdata (lane_wdata),
        .illegal    (illegal),
        .load_data  (load_data)
    );

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !pready_i) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = state == ST_ACCESS && !pready_i && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_next = illegal ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel_o     = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i || timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            funct_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i[PADDR_W+1:0];
                        wdata_q <= req_wdata_i;
                        funct_q <= req_funct_i;
                        if (illegal) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        err_q   <= pslverr_i;
                        rdata_q <= (pslverr_i || write_q) ? '0 : load_data;
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pwrite_o      = psel_o & write_q;
    assign paddr_o       = psel_o ? addr_q[PADDR_W+1:2] : '0;
    assign pwdata_o      = psel_o ? lane_wdata : '0;
    assign pstrb_o       = psel_o ? strb : '0;
    assign pfunct_code_o = psel_o ? funct_q : '0;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;

endmodule

// File: tb/tb_lsu_apb_master.sv
// Directed plus randomized bench for lsu_apb_master with an arithmetic reference model.
// Define APB_TIMEOUT_EN to also exercise the ACCESS timeout.
module tb_lsu_apb_master;

    localparam int unsigned TO = 16;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [5:0]  paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [2:0]  pfunct_code_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int unsigned checks = 0;
    int unsigned errors = 0;

    lsu_apb_master #(.PADDR_W(6), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_funct_i   (req_funct_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .pfunct_code_o (pfunct_code_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request through the DUT, compared cycle by cycle against the reference model.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f, input logic [31:0] rd,
                        input int unsigned waits, input bit slverr, input bit stuck);
        int unsigned size;
        int unsigned off;
        int unsigned resp_c;
        bit          legal_f;
        bit          bad;
        logic [31:0] mask;
        logic [31:0] v;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
        bit          exp_err;

        size    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        off     = addr % 4;
        legal_f = (f <= 3'd2) || (!wr && (f == 3'd4 || f == 3'd5));
        bad     = !legal_f || (off % size) != 0;
        exp_strb = wr ? 4'(((1 << size) - 1) << off) : 4'd0;
        exp_wd   = wr ? (wd << (8 * off)) : 32'd0;
        if (size == 4) begin
            v = rd;
        end else begin
            mask = 32'((64'd1 << (8 * size)) - 64'd1);
            v = (rd >> (8 * off)) & mask;
            if (!f[2] && v[8 * size - 1]) v = v | ~mask;
        end
        exp_err = bad || slverr || stuck;
        exp_rd  = (exp_err || wr) ? 32'd0 : v;
        resp_c  = bad ? 1 : stuck ? 2 + TO : 3 + waits;

        @(negedge clk_i);
        check("ready_idle", {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_funct_i = f;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        req_wdata_i = $urandom;
        for (int unsigned c = 1; c <= resp_c + 1; c++) begin
            @(negedge clk_i);
            if (bad || c >= resp_c) begin
                check("psel_off", {31'b0, psel_o}, 32'd0);
            end else begin
                check("psel", {31'b0, psel_o}, 32'd1);
                check("penable", {31'b0, penable_o}, {31'b0, c >= 2});
                check("paddr", {26'b0, paddr_o}, (addr >> 2) % 64);
                check("pstrb", {28'b0, pstrb_o}, {28'b0, exp_strb});
                check("pwdata", pwdata_o, exp_wd);
                check("pwrite", {31'b0, pwrite_o}, {31'b0, wr});
                check("pfunct", {29'b0, pfunct_code_o}, {29'b0, f});
            end
            check("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, c == resp_c});
            if (c >= resp_c) begin
                check("rsp_rdata", rsp_rdata_o, exp_rd);
                check("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
            end
            if (c == resp_c + 1) check("ready_back", {31'b0, req_ready_o}, 32'd1);
            pready_i  = !stuck && (waits == 0 || c == 2 + waits);
            prdata_i  = pready_i ? rd : $urandom;
            pslverr_i = pready_i && slverr;
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_funct_i = '0;
        prdata_i    = '0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_psel", {31'b0, psel_o}, 32'd0);
        check("rst_penable", {31'b0, penable_o}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst_pstrb", {28'b0, pstrb_o}, 32'd0);
        rst_ni = 1'b1;

        xfer(1'b1, 32'h08, 32'hDEADBEEF, 3'b010, 32'h0, 0, 1'b0, 1'b0);
        xfer(1'b1, 32'h0E, 32'h000000A5, 3'b000, 32'h0, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h0D, 32'h0, 3'b000, 32'h123480FF, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h0D, 32'h0, 3'b100, 32'h123480FF, 1, 1'b0, 1'b0);
        xfer(1'b0, 32'h0E, 32'h0, 3'b001, 32'h123480FF, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0, 3'b010, 32'hCAFEF00D, 3, 1'b0, 1'b0);
        xfer(1'b0, 32'h05, 32'h0, 3'b001, 32'h0, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h00, 32'h0, 3'b011, 32'h0, 0, 1'b0, 1'b0);
        xfer(1'b1, 32'h02, 32'h1234, 3'b101, 32'h0, 0, 1'b0, 1'b0);
        xfer(1'b0, 32'h04, 32'h0, 3'b010, 32'h55AA55AA, 2, 1'b1, 1'b0);
`ifdef APB_TIMEOUT_EN
        xfer(1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 0, 1'b0, 1'b1);
`endif

        // Reset pulse while the transfer sits in ACCESS.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 32'h10;
        req_funct_i = 3'b010;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("mid_psel", {31'b0, psel_o}, 32'd1);
        check("mid_penable", {31'b0, penable_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_psel", {31'b0, psel_o}, 32'd0);
        check("arst_penable", {31'b0, penable_o}, 32'd0);
        check("arst_ready", {31'b0, req_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("arst_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
            check("arst_idle_psel", {31'b0, psel_o}, 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom_range(1)), 32'($urandom_range(255)), $urandom,
                 3'($urandom_range(7)), $urandom, $urandom_range(3),
                 $urandom_range(7) == 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
